// File: rtl/txn_arb_pkg.sv
// Shared types and width helpers for the transaction arbiter.
package txn_arb_pkg;

  // Arbiter FSM: IDLE arbitrates, BURST forwards the owner's beats.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int MIN_REQ = 2;
  localparam int MAX_REQ = 16;

  // Index width for a vector of n requesters (never below one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold the value 'limit'.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req_i at or above
// ptr_i, wrapping from the top index back to 0.
module rr_picker
  import txn_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               found_o
);

  int idx;

  // Scan NUM_REQ positions starting at ptr_i; the first hit wins.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (!found_o && req_i[IDX_W'(idx)]) begin
        found_o  = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/txn_arbiter.sv
// Round-robin transaction arbiter: NUM_REQ valid/ready/last requesters share
// one output channel; a grant is held from the first beat to the last beat.
// Optional stall watchdog compiled in with `define TXN_ARB_WDOG_EN.
//
// Handshake: a beat moves when valid and ready are both high on a rising
// edge; valid never waits on ready, and only the owner sees out_ready.
// busy is the FSM state bit (1 = BURST), usable as the state debug view.
module txn_arbiter
  import txn_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          wdog_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e               state_q, state_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         pick_idx;
  logic [IDX_W-1:0]         next_ptr;
  logic                     pick_found;
  logic                     in_burst;
  logic                     beat_xfer;
  logic                     wdog_fire;
  logic [DATA_WIDTH-1:0]    data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_idx),
    .found_o  (pick_found)
  );

  assign in_burst  = (state_q == BURST);
  assign beat_xfer = out_valid & out_ready;
  assign next_ptr  = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
  assign busy      = in_burst;
  assign grant_id  = grant_q;

  // Owner's channel is steered straight through while in BURST.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    req_ready = '0;
    if (in_burst) begin
      out_valid          = req_valid[grant_q];
      out_data           = data_arr[grant_q];
      out_last           = req_last[grant_q];
      req_ready[grant_q] = out_ready;
    end
  end

  // Next state: grant in IDLE, release on last transfer or watchdog abort.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BURST;
        end
      end
      BURST: begin
        if ((beat_xfer && out_last) || wdog_fire) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef TXN_ARB_WDOG_EN
  localparam int CNT_W = cnt_width(WDOG_CYCLES);

  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_err_q, wdog_err_d;

  // Abort on the WDOG_CYCLES-th consecutive stalled BURST cycle.
  assign wdog_fire = in_burst && !beat_xfer &&
                     (wdog_cnt_q == CNT_W'(WDOG_CYCLES - 1));

  // Stall counter: zero in IDLE (so BURST starts at 0), cleared on transfer.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_fire;
    if (!in_burst || beat_xfer || wdog_fire) begin
      wdog_cnt_d = '0;
    end else begin
      wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
    end
  end

  // Watchdog counter and one-cycle error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  // Without the watchdog a stalled owner keeps the grant indefinitely.
  assign wdog_fire = 1'b0;
  assign wdog_err  = 1'b0;
`endif

endmodule
